// File: rtl/edge_detect_multi_if.sv
// Bundles the per-channel raw inputs, controls and detector outputs of edge_detect_multi.
interface edge_detect_multi_if #(
  parameter int unsigned CHANNELS = 4
) ();
  logic [CHANNELS-1:0]   raw;
  logic [2*CHANNELS-1:0] mode;
  logic [CHANNELS-1:0]   clear;
  logic [CHANNELS-1:0]   level;
  logic [CHANNELS-1:0]   edge_pulse;
  logic [CHANNELS-1:0]   event_flag;
  logic                  irq;

  modport master (
    output raw, mode, clear,
    input  level, edge_pulse, event_flag, irq
  );

  modport slave (
    input  raw, mode, clear,
    output level, edge_pulse, event_flag, irq
  );
endinterface

// File: rtl/edge_detect_multi.sv
// Multi-channel synchroniser + debounce + edge detector with per-channel mode,
// single-cycle pulses, sticky event flags and a combined interrupt.
module edge_detect_multi #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset,
  edge_detect_multi_if.slave bus
);
  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]       cnt_q  [CHANNELS];
  logic [CW-1:0]       cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] pulse_q, pulse_d;
  logic [CHANNELS-1:0] flag_q,  flag_d;
  logic [CHANNELS-1:0] sync_last;

  always_comb begin
    sync_last = sync_q[SYNC_STAGES-1];
    level_d   = level_q;
    pulse_d   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (sync_last[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          // Accept edge: mode is sampled only here, so mode changes alone never pulse.
          level_d[i] = sync_last[i];
          pulse_d[i] = sync_last[i] ? bus.mode[2*i] : bus.mode[2*i+1];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    // A new pulse overrides a simultaneous clear.
    flag_d = pulse_d | (flag_q & ~bus.clear);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      level_q <= '0;
      pulse_q <= '0;
      flag_q  <= '0;
    end else begin
      sync_q[0] <= bus.raw;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      for (int unsigned i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
      level_q <= level_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
    end
  end

  assign bus.level      = level_q;
  assign bus.edge_pulse = pulse_q;
  assign bus.event_flag = flag_q;
  assign bus.irq        = |flag_q;
endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
Parametrised multi-channel edge detector for asynchronous button/switch inputs. Each channel has a synchroniser, a debounce filter, and per-channel mode selection for rising, falling or both edges. Each channel drives a single-cycle pulse and a sticky event flag; a combined interrupt line is the OR of all flags. Sits between raw board inputs and the control FSMs that consume button presses.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 4, consecutive cycles a new level must persist before acceptance (>=1)

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-high; clears every register immediately
raw  input  CHANNELS  asynchronous raw inputs, bit i = channel i
mode  input  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
clear  input  CHANNELS  per-channel flag clear, level-sensitive, synchronous
level  output  CHANNELS  debounced level of each channel
edge_pulse  output  CHANNELS  one-cycle pulse per accepted edge matching mode
event_flag  output  CHANNELS  sticky flag, set by edge_pulse, cleared by clear
irq  output  1  OR of all event_flag bits

Behaviour:
- Reset (asynchronous, active-high): synchroniser chains, debounce counters, level, edge_pulse and event_flag all go to 0 while reset is high, regardless of clock. irq therefore also reads 0.
- Synchroniser: raw[i] shifts through SYNC_STAGES flops. The last stage output sync[i] is the only version of raw used downstream.
- Debounce, per channel, with counter cnt width clog2(DEBOUNCE_CYCLES+1):
  - sync == level: cnt <= 0.
  - sync != level and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync != level and cnt == DEBOUNCE_CYCLES-1: level <= sync, cnt <= 0. This edge is the accept edge.
  - A mismatch that ends before acceptance resets cnt, so glitches shorter than DEBOUNCE_CYCLES cycles are discarded.
  - DEBOUNCE_CYCLES=1: each new sync value is accepted on the first mismatching edge.
- Edge pulse:
  - On the accept edge, edge_pulse[i] <= 1 when (new level 1 and mode[2i]=1) or (new level 0 and mode[2i+1]=1). Otherwise edge_pulse[i] <= 0.
  - The pulse is registered: it is high for exactly the one cycle in which level first shows the new value.
  - Mode is sampled at the accept edge only. Changing mode never generates a pulse.
  - Mode 00: level still tracks the input; no pulses, no flags.
- Latency: a raw change stable before posedge k gives level and edge_pulse high after posedge k+SYNC_STAGES+DEBOUNCE_CYCLES-1, i.e. visible during cycle SYNC_STAGES+DEBOUNCE_CYCLES counted from sampling edge k as cycle 1. With defaults this is 6 edges.
- Event flag:
  - edge_pulse[i]=1 sets event_flag[i] on the same edge edge_pulse is asserted, so both rise together.
  - clear[i]=1 clears it on the next edge.
  - Simultaneous set and clear: set wins, flag stays 1.
  - A flag already set stays set; there is no counting.
- irq: combinational OR of event_flag. No extra latency.
- Channels are fully independent. Simultaneous events on several channels all produce pulses in the same cycle.
- Reset release with raw held high: level starts at 0, so after the normal latency the channel accepts a 0->1 transition. A rise-enabled channel reports one rising pulse. This start-up edge is intended behaviour.
- Reset asserted mid-debounce: the partial count is discarded and no pulse is produced.

Test Plan:
- Reset check: drive raw=4'b1111 and toggle mode during reset -> level, edge_pulse, event_flag = 0 and irq=0 throughout reset. After release, mode=01 on all channels gives one edge_pulse=4'b1111, 6 edges after the first sampling edge.
- Basic rise: mode=8'b01_01_01_01, raw[0] 0->1 and held -> edge_pulse[0] high for exactly 1 cycle, 6 edges later. level[0]=1 from the same cycle; event_flag[0]=1 and irq=1 from the same cycle.
- Glitch rejection: raw[1] high for 3 cycles then low -> level[1] stays 0 and no pulse. Next, raw[1] high for 4 cycles -> exactly one pulse.
- Modes: channel 2 in mode 10, raw[2] 0->1->0 with each level held 10 cycles -> a single pulse on the falling edge only. Same stimulus in mode 11 -> two pulses. Mode 00 -> none, but level[2] still follows the input.
- Flag clear race: hold clear[3]=1 during the cycle edge_pulse[3] asserts -> event_flag[3]=1 afterwards. clear[3] for one later cycle -> flag goes to 0 and irq drops if no other flags are set.
- Reset mid-debounce: raw[0] rises, reset pulses (asynchronous, between clock edges) 3 cycles later -> outputs go to 0 immediately. After release with raw[0] still high, exactly one pulse arrives a full 6 edges later.
